// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: counter width, legal
// oversampling ratios, frame bit-count limits and the sample-vote helpers.
package uart_rx_pkg;

  localparam int CNT_W = 6;

  // Legal oversampling ratios.
  localparam logic [CNT_W-1:0] PRESC_8  = CNT_W'(8);
  localparam logic [CNT_W-1:0] PRESC_16 = CNT_W'(16);
  localparam logic [CNT_W-1:0] PRESC_32 = CNT_W'(32);

  // bit_cnt values at which the receive FSM moves to its next check.
  localparam int START_DONE   = 1;
  localparam int DATA_DONE    = 9;
  localparam int PAR_DONE     = 10;
  localparam int STP_DONE_PAR = 11;

  // Three samples taken around a bit centre, s0 earliest.
  typedef struct packed {
    logic s2;
    logic s1;
    logic s0;
  } samp_t;

  // Samples idle at the line's idle level.
  localparam samp_t SAMP_IDLE = '{s2: 1'b1, s1: 1'b1, s0: 1'b1};

  // 2-of-3 vote.
  function automatic logic majority3(input samp_t s);
    return (s.s0 & s.s1) | (s.s0 & s.s2) | (s.s1 & s.s2);
  endfunction

endpackage

// File: rtl/rx_edge_sampler_if.sv
// Signal bundle between the receive FSM side (master) and the
// oversampling front end (slave).
interface rx_edge_sampler_if #(
  parameter int CNT_W = uart_rx_pkg::CNT_W
);

  logic             RX_IN;
  logic [CNT_W-1:0] Prescale;
  logic             enable;
  logic             dat_samp_en;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             sampled_bit;
  logic             sample_valid;

  modport master (
    output RX_IN, Prescale, enable, dat_samp_en,
    input  edge_cnt, bit_cnt, sampled_bit, sample_valid
  );

  modport slave (
    input  RX_IN, Prescale, enable, dat_samp_en,
    output edge_cnt, bit_cnt, sampled_bit, sample_valid
  );

endinterface

// File: rtl/rx_edge_sampler_edge_bit_counter.sv
// Oversampling-clock counter (edge_cnt) and bit-period counter (bit_cnt).
// edge_cnt wraps at Prescale-1; bit_cnt counts wraps and saturates.
module edge_bit_counter #(
  parameter int CNT_W = uart_rx_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] prescale,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] last_edge;
  logic             bit_cnt_max;

  assign last_edge   = prescale - CNT_W'(1);
  assign bit_cnt_max = (bit_cnt_q == {CNT_W{1'b1}});

  // Next counter values; disable clears both, even on a wrap clock.
  // The >= wrap also recovers if Prescale is lowered below edge_cnt.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!enable) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (edge_cnt_q >= last_edge) begin
      edge_cnt_d = '0;
      if (!bit_cnt_max) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/rx_edge_sampler.sv
// UART receiver oversampling front end: counters plus a three-point
// majority-voted sample of RX_IN around each bit centre.
module rx_edge_sampler #(
  parameter int CNT_W = uart_rx_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  rx_edge_sampler_if.slave  bus
);

  import uart_rx_pkg::*;

  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cap0_edge, cap1_edge, cap2_edge, vote_edge;

  samp_t samp_q, samp_d;
  logic  sampled_bit_q, sampled_bit_d;
  logic  sample_valid_q, sample_valid_d;

  edge_bit_counter #(
    .CNT_W    (CNT_W)
  ) u_edge_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .prescale (bus.Prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  // Capture points straddle the bit centre; the vote follows the last one.
  always_comb begin
    half      = bus.Prescale >> 1;
    cap0_edge = half - CNT_W'(1);
    cap1_edge = half;
    cap2_edge = half + CNT_W'(1);
    vote_edge = half + CNT_W'(2);
  end

  // Capture RX_IN into the sample register matching the current edge.
  always_comb begin
    samp_d = samp_q;
    if (bus.dat_samp_en) begin
      if (edge_cnt == cap0_edge) samp_d.s0 = bus.RX_IN;
      if (edge_cnt == cap1_edge) samp_d.s1 = bus.RX_IN;
      if (edge_cnt == cap2_edge) samp_d.s2 = bus.RX_IN;
    end
  end

  // Vote on the registered samples one clock after the last capture.
  always_comb begin
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (bus.enable && (edge_cnt == vote_edge)) begin
      sampled_bit_d  = majority3(samp_q);
      sample_valid_d = 1'b1;
    end
  end

  // Sample and decision registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q         <= SAMP_IDLE;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
    end else begin
      samp_q         <= samp_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.edge_cnt     = edge_cnt;
  assign bus.bit_cnt      = bit_cnt;
  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_rx_edge_sampler.sv
// Bench for rx_edge_sampler: frame-time model checked every cycle plus
// directed literal checks for reset, counting, glitch, frame, drop, saturation.
module tb_rx_edge_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_edge_sampler_if #(.CNT_W(6)) bus ();

  rx_edge_sampler #(.CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: t = number of enabled clocks since enable last sampled low.
  int t;
  int m_s0, m_s1, m_s2;
  int m_sb, m_sv;

  function automatic int presc();
    return (int'(bus.Prescale) == 0) ? 1 : int'(bus.Prescale);
  endfunction

  function automatic int m_edge();
    return t % presc();
  endfunction

  function automatic int m_bit();
    int b;
    b = t / presc();
    return (b > 63) ? 63 : b;
  endfunction

  always @(posedge clk or posedge rst) begin
    int e, h;
    if (rst) begin
      t = 0; m_s0 = 1; m_s1 = 1; m_s2 = 1; m_sb = 1; m_sv = 0;
    end else begin
      e = m_edge();
      h = presc() / 2;
      if (bus.dat_samp_en) begin
        if (e == h - 1) m_s0 = int'(bus.RX_IN);
        if (e == h)     m_s1 = int'(bus.RX_IN);
        if (e == h + 1) m_s2 = int'(bus.RX_IN);
      end
      m_sv = 0;
      if (bus.enable && e == h + 2) begin
        m_sb = ((m_s0 + m_s1 + m_s2) >= 2) ? 1 : 0;
        m_sv = 1;
      end
      t = bus.enable ? t + 1 : 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("edge_cnt", int'(bus.edge_cnt), m_edge());
    chk("bit_cnt", int'(bus.bit_cnt), m_bit());
    chk("sampled_bit", int'(bus.sampled_bit), m_sb);
    chk("sample_valid", int'(bus.sample_valid), m_sv);
  end

  // Stimulus: 0 idle high, 1 low with glitch at edge 8, 2 framed bits.
  int rx_mode = 0;
  logic [8:0] frame_bits;

  task automatic step(input logic en);
    int e, h, idx;
    @(negedge clk);
    bus.enable = en;
    e = m_edge();
    h = presc() / 2;
    bus.dat_samp_en = en && (e >= h - 1) && (e <= h + 1);
    case (rx_mode)
      1: bus.RX_IN = (e == 8);
      2: begin
        idx = t / presc();
        bus.RX_IN = (idx <= 8) ? frame_bits[idx] : 1'b1;
      end
      default: bus.RX_IN = 1'b1;
    endcase
  endtask

  int exp_frame [9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    int sv_edge, sv_count, k, sb_before;
    bus.RX_IN = 1'b1;
    bus.Prescale = 6'd8;
    bus.enable = 1'b0;
    bus.dat_samp_en = 1'b0;
    frame_bits = {8'hA5, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-count at edge 5, bit 3.
    repeat (30) step(1'b1);
    chk("pre_reset_edge", int'(bus.edge_cnt), 5);
    chk("pre_reset_bit", int'(bus.bit_cnt), 3);
    #2 rst = 1'b1;
    #1;
    chk("reset_edge", int'(bus.edge_cnt), 0);
    chk("reset_bit", int'(bus.bit_cnt), 0);
    chk("reset_sampled_bit", int'(bus.sampled_bit), 1);
    chk("reset_sample_valid", int'(bus.sample_valid), 0);
    @(negedge clk);
    bus.enable = 1'b0;
    bus.dat_samp_en = 1'b0;
    rst = 1'b0;
    repeat (2) step(1'b0);

    // Counting: 88 enabled clocks at P=8.
    repeat (89) step(1'b1);
    chk("count_bit_11", int'(bus.bit_cnt), 11);
    chk("count_edge_0", int'(bus.edge_cnt), 0);
    chk("count_idle_bit", int'(bus.sampled_bit), 1);
    repeat (2) step(1'b0);

    // Glitch rejection at P=16.
    bus.Prescale = 6'd16;
    rx_mode = 1;
    sv_edge = -1;
    sv_count = 0;
    repeat (16) begin
      step(1'b1);
      if (bus.sample_valid) begin
        sv_edge = int'(bus.edge_cnt);
        sv_count++;
      end
    end
    chk("glitch_sampled_bit", int'(bus.sampled_bit), 0);
    chk("glitch_valid_edge_after_10", sv_edge, 11);
    chk("glitch_valid_pulses", sv_count, 1);
    rx_mode = 0;
    repeat (2) step(1'b0);

    // Frame: start bit then 0xA5 LSB first at P=32.
    bus.Prescale = 6'd32;
    rx_mode = 2;
    k = 0;
    repeat (9 * 32) begin
      step(1'b1);
      if (int'(bus.edge_cnt) == 31 && k < 9) begin
        chk("frame_bit", int'(bus.sampled_bit), exp_frame[k]);
        k++;
      end
    end
    chk("frame_bits_seen", k, 9);
    rx_mode = 0;
    repeat (2) step(1'b0);

    // Enable drop on the wrap clock with bit_cnt=4.
    bus.Prescale = 6'd8;
    repeat (39) step(1'b1);
    step(1'b0);
    chk("drop_pre_edge", int'(bus.edge_cnt), 7);
    chk("drop_pre_bit", int'(bus.bit_cnt), 4);
    sb_before = int'(bus.sampled_bit);
    step(1'b0);
    chk("drop_edge", int'(bus.edge_cnt), 0);
    chk("drop_bit", int'(bus.bit_cnt), 0);
    chk("drop_sampled_bit_held", int'(bus.sampled_bit), sb_before);

    // Saturation: 600 enabled clocks at P=8.
    repeat (601) step(1'b1);
    chk("sat_bit", int'(bus.bit_cnt), 63);
    chk("sat_edge", int'(bus.edge_cnt), 0);
    step(1'b1);
    chk("sat_bit_hold", int'(bus.bit_cnt), 63);
    chk("sat_edge_wraps", int'(bus.edge_cnt), 1);
    repeat (2) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
